ipg_tx_inserter: RTL and testbench
==================================

// Module: ipg_tx_inserter
// PURPOSE
//  TX-side counterpart of the IPG receive path. Sits between xgmii_baser_enc_64 and the TX
//  SERDES interface on the encoded 64b/66b stream. Replaces eligible all-idle control blocks
//  with IPG data blocks carrying up to 48 payload bits from a valid/ready side channel.
//  ipg_rx strips these blocks and restores them to idles. All other blocks pass unmodified.
// PARAMETERS
//  DATA_WIDTH       64     encoded block width; only 64 is legal
//  HDR_WIDTH        2      sync header width; only 2 is legal
//  IPG_BTYPE        8'h1F  block type marking an IPG block; unused by Clause 49
//  MIN_IDLE_BLOCKS  1      idle blocks after a terminate that pass untouched (0..15)
// PORTS
//  clk                  in   1   PHY TX clock
//  rst_n                in   1   asynchronous reset, active low
//  encoded_tx_data_in   in   64  block from encoder
//  encoded_tx_hdr_in    in   2   sync header from encoder
//  encoded_tx_data_out  out  64  block to SERDES interface
//  encoded_tx_hdr_out   out  2   sync header to SERDES interface
//  tx_ipg_data          in   48  payload; bit 0 is sent first
//  tx_ipg_len           in   6   payload length in bits (1..48)
//  tx_ipg_valid         in   1   payload offered
//  tx_ipg_ready         out  1   payload holding register can accept
//  tx_ipg_sent          out  1   one-cycle pulse: an IPG block left on *_out this cycle
//  tx_ipg_count         out  16  IPG blocks sent; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset values: data_out = 64'h1E (idle block), hdr_out = 2'b10, tx_ipg_ready = 0,
//    tx_ipg_sent = 0, tx_ipg_count = 0, holding register empty, FSM = GUARD,
//    guard counter = MIN_IDLE_BLOCKS. tx_ipg_ready rises on the first clk after reset release.
//  - Latency: exactly 1 clk, input block to output, for every block. There is no bubble
//    and no back-pressure on the encoded stream.
//  - Idle block: hdr == 2'b10, data[7:0] == 8'h1E, and data[63:8] == 0.
//  - IPG block: hdr 2'b10, data[7:0] = IPG_BTYPE, data[15:8] = {2'b00,len},
//    data[63:16] = payload. Payload bits at or above len are forced to 0.
//  - Handshake: the transfer happens when tx_ipg_valid && tx_ipg_ready. There is one
//    holding register.
//    - tx_ipg_ready = holding register empty, OR the held payload is inserted this cycle
//      (same-cycle refill).
//    - len == 0: accepted and discarded; nothing is inserted.
//    - len > 48: clamped to 48.
//  - FSM, evaluated on each valid-header input block:
//    - GUARD:
//      - Idle block with guard counter > 0: decrement the counter; the block passes.
//      - Idle block with guard counter == 0: go to ARMED; this block is also eligible.
//    - ARMED: an idle block is replaced if the holding register is full; otherwise it passes.
//    - Start block (type 8'h78 or 8'h33) in any state: go to IN_FRAME.
//    - Terminate block (8'h87/99/AA/B4/CC/D2/E1/FF) in any state: go to GUARD; load the
//      guard counter with MIN_IDLE_BLOCKS.
//    - Ordered-set and other control types pass. They do not change the state and do not
//      decrement the guard counter.
//    - Data blocks (hdr 2'b01) pass and do not change the state.
//    - hdr 2'b00 / 2'b11 pass unchanged. They do not change the state or the counter.
//    - MIN_IDLE_BLOCKS = 0: the first idle after a terminate is eligible.
//  - Idle blocks are never replaced while in IN_FRAME.
//  - Insertion cycle: the holding register empties, tx_ipg_sent pulses with the output
//    block, and tx_ipg_count increments.
//  - Reset mid-operation: a held payload is lost and the output returns to idle
//    immediately (asynchronous reset).
// STRUCTURE
//  - Shared package ipg_pkg (also used by ipg_rx):
//    - constants SYNC_DATA, SYNC_CTRL, BTYPE_IDLE, IPG_BTYPE_DEFAULT, IPG_MAX_BITS = 48
//    - the terminate and start type lists
//    - IPG block pack/unpack functions
//  - One sub-module, ipg_tx_skid: the holding register and valid/ready logic,
//    including len clamping and payload masking.
//  - The FSM, guard counter, block classifier and output register live in the top level.
// TESTING
//  1. Reset with rst_n low for 3 clk and an idle stream -> out == {2'b10, 64'h1E}.
//     tx_ipg_ready = 0 while in reset and = 1 one clk after release.
//  2. MIN_IDLE_BLOCKS = 1. Sequence: start, 3 data, terminate 8'hFF, 4 idles. Offer
//     payload 48'hABCD_1234_5678 with len 48 while in frame. -> First idle after the
//     terminate passes. The second is output as data 64'hABCD_1234_5678_301F with one
//     tx_ipg_sent pulse; count = 1.
//  3. Offer len 12, data 48'hFFFF_FFFF_FFFF, while ARMED.
//     -> Inserted block data = 64'h0000_0000_0FFF_0C1F.
//  4. Offer len 0 -> accepted; no block is altered; count is unchanged.
//     Offer len 63 -> inserted block carries byte 1 = 8'h30.
//  5. Hold valid high with 5 payloads across 5 consecutive ARMED idles -> 5 back-to-back
//     IPG blocks, with ready held high through the same-cycle refill.
//     Inject hdr 2'b11 mid-stream -> it passes unchanged and the state is unchanged.
//  6. Assert rst_n low while a payload is held -> next output after release is idle and
//     count = 0. Pre-load count to 16'hFFFF and insert -> count stays 16'hFFFF.

Source files
------------

// File: rtl/ipg_pkg.sv
// Shared 64b/66b IPG block definitions for the TX inserter and the RX stripper.
// Holds sync/type constants, the block classifiers and the IPG block pack/unpack helpers.
package ipg_pkg;

   localparam logic [1:0] SYNC_DATA         = 2'b01;
   localparam logic [1:0] SYNC_CTRL         = 2'b10;
   localparam logic [7:0] BTYPE_IDLE        = 8'h1E;
   localparam logic [7:0] IPG_BTYPE_DEFAULT = 8'h1F;
   localparam int         IPG_MAX_BITS      = 48;
   localparam int         IPG_LEN_W         = 6;

   typedef enum logic [1:0] {
      ST_GUARD,
      ST_ARMED,
      ST_IN_FRAME
   } tx_state_e;

   typedef struct packed {
      logic [IPG_LEN_W-1:0]    len;
      logic [IPG_MAX_BITS-1:0] dat;
   } ipg_payload_t;

   typedef struct packed {
      logic                    ok;
      logic [IPG_LEN_W-1:0]    len;
      logic [IPG_MAX_BITS-1:0] dat;
   } ipg_unpacked_t;

   function automatic logic is_start(input logic [7:0] btype);
      return btype inside {8'h78, 8'h33};
   endfunction

   function automatic logic is_term(input logic [7:0] btype);
      return btype inside {8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
   endfunction

   function automatic logic [63:0] ipg_pack(input logic [7:0] btype, input ipg_payload_t p);
      return {p.dat, 2'b00, p.len, btype};
   endfunction

   // ok flags a well-formed IPG block; the caller still checks the sync header.
   function automatic ipg_unpacked_t ipg_unpack(input logic [7:0] btype, input logic [63:0] blk);
      ipg_unpacked_t u;
      u.ok  = (blk[7:0] == btype) && (blk[15:14] == 2'b00);
      u.len = blk[13:8];
      u.dat = blk[63:16];
      return u;
   endfunction

endpackage

// File: rtl/ipg_tx_inserter_if.sv
// Encoded TX stream plus IPG payload side channel; master drives the encoder side,
// slave is the inserter.
interface ipg_tx_inserter_if;
   import ipg_pkg::*;

   logic [63:0]             encoded_tx_data_in;
   logic [1:0]              encoded_tx_hdr_in;
   logic [63:0]             encoded_tx_data_out;
   logic [1:0]              encoded_tx_hdr_out;
   logic [IPG_MAX_BITS-1:0] tx_ipg_data;
   logic [IPG_LEN_W-1:0]    tx_ipg_len;
   logic                    tx_ipg_valid;
   logic                    tx_ipg_ready;
   logic                    tx_ipg_sent;
   logic [15:0]             tx_ipg_count;

   modport master (
      output encoded_tx_data_in, encoded_tx_hdr_in, tx_ipg_data, tx_ipg_len, tx_ipg_valid,
      input  encoded_tx_data_out, encoded_tx_hdr_out, tx_ipg_ready, tx_ipg_sent, tx_ipg_count
   );

   modport slave (
      input  encoded_tx_data_in, encoded_tx_hdr_in, tx_ipg_data, tx_ipg_len, tx_ipg_valid,
      output encoded_tx_data_out, encoded_tx_hdr_out, tx_ipg_ready, tx_ipg_sent, tx_ipg_count
   );

endinterface

// File: rtl/ipg_tx_skid.sv
// One-entry IPG payload holding register; clamps len to 48 and zeroes bits above len.
// Latency 1 clk to held; ready = empty or being drained this cycle; len 0 is swallowed.
module ipg_tx_skid
   import ipg_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [IPG_MAX_BITS-1:0] in_dat,
   input  logic [IPG_LEN_W-1:0]    in_len,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic                    take,
   output logic                    held_vld,
   output ipg_payload_t            held
);

   logic                    rdy_en;
   logic                    accept;
   logic [IPG_LEN_W-1:0]    len_clamped;
   logic [IPG_MAX_BITS-1:0] mask;

   always_comb begin
      len_clamped = (in_len > IPG_LEN_W'(IPG_MAX_BITS)) ? IPG_LEN_W'(IPG_MAX_BITS) : in_len;
      mask        = (len_clamped == IPG_LEN_W'(IPG_MAX_BITS)) ? '1
                  : ((IPG_MAX_BITS'(1) << len_clamped) - IPG_MAX_BITS'(1));
      in_rdy      = rdy_en && (!held_vld || take);
      accept      = in_vld && in_rdy;
   end

   // rdy_en keeps ready low through reset and for the edge that releases it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en   <= 1'b0;
         held_vld <= 1'b0;
         held     <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (accept && (len_clamped != '0)) begin
            held_vld <= 1'b1;
            held.len <= len_clamped;
            held.dat <= in_dat & mask;
         end else if (accept || take) begin
            held_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ipg_tx_inserter.sv
// Replaces eligible inter-frame idle blocks with IPG blocks carrying side-channel payload.
// Latency 1 clk for every block; no backpressure on the encoded stream, payload via valid/ready.
module ipg_tx_inserter
   import ipg_pkg::*;
#(
   parameter int         DATA_WIDTH      = 64,
   parameter int         HDR_WIDTH       = 2,
   parameter logic [7:0] IPG_BTYPE       = IPG_BTYPE_DEFAULT,
   parameter int         MIN_IDLE_BLOCKS = 1
) (
   input logic               clk,
   input logic               rst_n,
   ipg_tx_inserter_if.slave  bus
);

   if (DATA_WIDTH != 64 || HDR_WIDTH != 2 || MIN_IDLE_BLOCKS < 0 || MIN_IDLE_BLOCKS > 15) begin : g_bad_param
      $error("ipg_tx_inserter: unsupported parameter value");
   end

   localparam logic [3:0] GUARD_INIT = 4'(MIN_IDLE_BLOCKS);

   tx_state_e    state_q, state_nxt;
   logic [3:0]   guard_q, guard_nxt;
   logic         is_ctrl, is_idle, eligible, insert;
   logic         held_vld;
   ipg_payload_t held;
   logic [63:0]  data_q;
   logic [1:0]   hdr_q;
   logic         sent_q;
   logic [15:0]  count_q;

   ipg_tx_skid u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_dat   (bus.tx_ipg_data),
      .in_len   (bus.tx_ipg_len),
      .in_vld   (bus.tx_ipg_valid),
      .in_rdy   (bus.tx_ipg_ready),
      .take     (insert),
      .held_vld (held_vld),
      .held     (held)
   );

   always_comb begin
      is_ctrl = (bus.encoded_tx_hdr_in == SYNC_CTRL);
      is_idle = is_ctrl && (bus.encoded_tx_data_in == {56'd0, BTYPE_IDLE});
   end

   always_comb begin
      state_nxt = state_q;
      guard_nxt = guard_q;
      eligible  = 1'b0;
      if (is_idle) begin
         case (state_q)
            ST_GUARD: begin
               if (guard_q != 4'd0) begin
                  guard_nxt = guard_q - 4'd1;
               end else begin
                  state_nxt = ST_ARMED;
                  eligible  = 1'b1;
               end
            end
            ST_ARMED: eligible = 1'b1;
            default:  ;
         endcase
      end else if (is_ctrl && is_start(bus.encoded_tx_data_in[7:0])) begin
         state_nxt = ST_IN_FRAME;
      end else if (is_ctrl && is_term(bus.encoded_tx_data_in[7:0])) begin
         state_nxt = ST_GUARD;
         guard_nxt = GUARD_INIT;
      end
      insert = eligible && held_vld;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_GUARD;
         guard_q <= GUARD_INIT;
         data_q  <= {56'd0, BTYPE_IDLE};
         hdr_q   <= SYNC_CTRL;
         sent_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_nxt;
         guard_q <= guard_nxt;
         data_q  <= insert ? ipg_pack(IPG_BTYPE, held) : bus.encoded_tx_data_in;
         hdr_q   <= bus.encoded_tx_hdr_in;
         sent_q  <= insert;
         if (insert && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign bus.encoded_tx_data_out = data_q;
   assign bus.encoded_tx_hdr_out  = hdr_q;
   assign bus.tx_ipg_sent         = sent_q;
   assign bus.tx_ipg_count        = count_q;

endmodule

// File: tb/tb_ipg_tx_inserter.sv
// Directed bench for ipg_tx_inserter with MIN_IDLE_BLOCKS = 1.
module tb_ipg_tx_inserter;

   localparam logic [65:0] IDLE  = {2'b10, 64'h0000_0000_0000_001E};
   localparam logic [63:0] START = 64'h5555_5555_5555_5578;
   localparam logic [63:0] TERM  = 64'h0000_0000_0000_00FF;
   localparam logic [63:0] DATA  = 64'hD0D0_D0D0_D0D0_D0D0;

   logic clk = 1'b0;
   logic rst_n;
   logic rdy_seen;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ipg_tx_inserter_if bus ();

   ipg_tx_inserter #(.MIN_IDLE_BLOCKS(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one block, note ready before the edge, then settle past the edge.
   task automatic cyc(input logic [1:0] h, input logic [63:0] d);
      bus.encoded_tx_hdr_in  = h;
      bus.encoded_tx_data_in = d;
      #1 rdy_seen = bus.tx_ipg_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(IDLE[65:64], IDLE[63:0]);
   endtask

   task automatic offer(input logic [47:0] d, input logic [5:0] l);
      bus.tx_ipg_data  = d;
      bus.tx_ipg_len   = l;
      bus.tx_ipg_valid = 1'b1;
   endtask

   task automatic drop();
      bus.tx_ipg_valid = 1'b0;
   endtask

   function automatic logic [65:0] out_blk();
      return {bus.encoded_tx_hdr_out, bus.encoded_tx_data_out};
   endfunction

   function automatic logic [65:0] ipg48(input logic [47:0] p);
      return {2'b10, p, 8'h30, 8'h1F};
   endfunction

   initial begin
      rst_n = 1'b0;
      bus.encoded_tx_hdr_in  = IDLE[65:64];
      bus.encoded_tx_data_in = IDLE[63:0];
      bus.tx_ipg_data  = '0;
      bus.tx_ipg_len   = '0;
      bus.tx_ipg_valid = 1'b0;

      // 1. reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", out_blk(), IDLE);
      chk("rst_ready", 66'(bus.tx_ipg_ready), 66'd0);
      chk("rst_sent", 66'(bus.tx_ipg_sent), 66'd0);
      chk("rst_count", 66'(bus.tx_ipg_count), 66'd0);
      rst_n = 1'b1;
      idle();
      chk("ready_before_first_edge", 66'(rdy_seen), 66'd0);
      chk("ready_after_release", 66'(bus.tx_ipg_ready), 66'd1);

      // 2. frame, payload held in frame, guard of one idle
      cyc(2'b10, START);
      chk("start_pass", out_blk(), {2'b10, START});
      offer(48'hABCD_1234_5678, 6'd48);
      cyc(2'b01, DATA);
      drop();
      chk("t2_accept_ready", 66'(rdy_seen), 66'd1);
      chk("data_pass", out_blk(), {2'b01, DATA});
      idle();
      chk("in_frame_idle_kept", out_blk(), IDLE);
      chk("in_frame_no_sent", 66'(bus.tx_ipg_sent), 66'd0);
      cyc(2'b01, DATA);
      cyc(2'b10, TERM);
      chk("term_pass", out_blk(), {2'b10, TERM});
      idle();
      chk("guard_idle", out_blk(), IDLE);
      chk("guard_no_sent", 66'(bus.tx_ipg_sent), 66'd0);
      idle();
      chk("t2_ipg", out_blk(), {2'b10, 64'hABCD_1234_5678_301F});
      chk("t2_sent", 66'(bus.tx_ipg_sent), 66'd1);
      chk("t2_count", 66'(bus.tx_ipg_count), 66'd1);
      idle();
      chk("t2_after", out_blk(), IDLE);
      chk("t2_sent_pulse", 66'(bus.tx_ipg_sent), 66'd0);

      // 3. len 12 masks payload
      offer(48'hFFFF_FFFF_FFFF, 6'd12);
      idle();
      drop();
      chk("t3_accept_pass", out_blk(), IDLE);
      idle();
      chk("t3_ipg", out_blk(), {2'b10, 64'h0000_0000_0FFF_0C1F});
      chk("t3_count", 66'(bus.tx_ipg_count), 66'd2);

      // 4. len 0 discarded, len 63 clamped
      offer(48'h1111_2222_3333, 6'd0);
      idle();
      drop();
      chk("len0_ready", 66'(rdy_seen), 66'd1);
      idle();
      chk("len0_out", out_blk(), IDLE);
      chk("len0_sent", 66'(bus.tx_ipg_sent), 66'd0);
      chk("len0_count", 66'(bus.tx_ipg_count), 66'd2);
      offer(48'h1234_5678_9ABC, 6'd63);
      idle();
      drop();
      idle();
      chk("len63_ipg", out_blk(), {2'b10, 64'h1234_5678_9ABC_301F});
      chk("len63_count", 66'(bus.tx_ipg_count), 66'd3);

      // 5. back-to-back with same-cycle refill
      for (int k = 0; k < 6; k++) begin
         if (k < 5) offer(48'hC0DE_0000_0000 + 48'(k), 6'd48);
         else       drop();
         idle();
         if (k < 5) chk($sformatf("b2b_ready_%0d", k), 66'(rdy_seen), 66'd1);
         if (k == 0) begin
            chk("b2b_first_pass", out_blk(), IDLE);
         end else begin
            chk($sformatf("b2b_ipg_%0d", k), out_blk(), ipg48(48'hC0DE_0000_0000 + 48'(k - 1)));
            chk($sformatf("b2b_sent_%0d", k), 66'(bus.tx_ipg_sent), 66'd1);
         end
      end
      chk("b2b_count", 66'(bus.tx_ipg_count), 66'd8);
      offer(48'h0000_BEEF_0005, 6'd48);
      cyc(2'b11, IDLE[63:0]);
      drop();
      chk("hdr11_pass", out_blk(), {2'b11, IDLE[63:0]});
      chk("hdr11_no_sent", 66'(bus.tx_ipg_sent), 66'd0);
      idle();
      chk("after_hdr11_ipg", out_blk(), ipg48(48'h0000_BEEF_0005));
      chk("after_hdr11_count", 66'(bus.tx_ipg_count), 66'd9);

      // 6. reset with a held payload, then counter saturation
      cyc(2'b10, START);
      offer(48'h0000_DEAD_0006, 6'd48);
      cyc(2'b01, DATA);
      drop();
      bus.encoded_tx_hdr_in  = IDLE[65:64];
      bus.encoded_tx_data_in = IDLE[63:0];
      rst_n = 1'b0;
      #1;
      chk("arst_out", out_blk(), IDLE);
      chk("arst_count", 66'(bus.tx_ipg_count), 66'd0);
      chk("arst_ready", 66'(bus.tx_ipg_ready), 66'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle();
      chk("post_rst_idle0", out_blk(), IDLE);
      idle();
      chk("post_rst_idle1", out_blk(), IDLE);
      chk("post_rst_lost", 66'(bus.tx_ipg_sent), 66'd0);
      chk("post_rst_count", 66'(bus.tx_ipg_count), 66'd0);
      offer(48'h0000_0000_0001, 6'd1);
      idle();
      repeat (65535) idle();
      chk("sat_reach", 66'(bus.tx_ipg_count), 66'hFFFF);
      chk("sat_blk", out_blk(), {2'b10, 64'h0000_0000_0001_011F});
      idle();
      drop();
      chk("sat_sent", 66'(bus.tx_ipg_sent), 66'd1);
      chk("sat_hold", 66'(bus.tx_ipg_count), 66'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
